// File: rtl/fifo_read_streamer_pkg.sv
// Shared definitions for the FIFO read-side stream adapter and any matching
// write-side stream feeder: occupancy encodings, buffer entry type, helpers.
package fifo_read_streamer_pkg;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;

    // Default word width of a stream entry; modules with a different width
    // build their own entry struct of the same shape.
    localparam int unsigned ENTRY_DSIZE = 8;

    // One buffered stream word together with its end-of-burst tag.
    typedef struct packed {
        logic                   last;
        logic [ENTRY_DSIZE-1:0] data;
    } stream_entry_t;

    // Occupancy after one cycle: add a push, remove a pop, clamp to 0..2.
    // A push into a full buffer without a pop is dropped.
    function automatic logic [1:0] occ_next(input logic [1:0] occ,
                                            input logic       push,
                                            input logic       pop);
        logic [2:0] sum_v;
        sum_v = {1'b0, occ} + {2'b00, push};
        if (pop && (sum_v != 3'd0)) begin
            sum_v = sum_v - 3'd1;
        end else begin
            sum_v = sum_v;
        end
        if (sum_v > 3'd2) begin
            sum_v = 3'd2;
        end else begin
            sum_v = sum_v;
        end
        return sum_v[1:0];
    endfunction

endpackage

// File: rtl/stream_buf2.sv
// Two-entry ordered register buffer. The head entry is always the oldest word
// and is presented directly from a register; flush empties the buffer.
module stream_buf2
    import fifo_read_streamer_pkg::*;
#(
    parameter type entry_t = stream_entry_t
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       push,
    input  entry_t     push_entry,
    input  logic       pop,
    output entry_t     head,
    output logic       head_valid,
    output logic [1:0] occupancy
);

    entry_t     head_r;
    entry_t     tail_r;
    entry_t     head_s;
    entry_t     tail_s;
    logic [1:0] occ_r;
    logic [1:0] occ_s;
    logic       valid_r;

    // Next-state of the two slots: new words land in the first free slot,
    // a pop promotes the tail (or an incoming word) to the head.
    always_comb begin
        head_s = head_r;
        tail_s = tail_r;
        occ_s  = occ_r;
        if (flush) begin
            occ_s = OCC_EMPTY;
        end else begin
            case (occ_r)
                OCC_EMPTY: begin
                    if (push) begin
                        head_s = push_entry;
                    end else begin
                        head_s = head_r;
                    end
                end
                OCC_ONE: begin
                    if (push && pop) begin
                        head_s = push_entry;
                    end else if (push) begin
                        tail_s = push_entry;
                    end else begin
                        head_s = head_r;
                    end
                end
                OCC_FULL: begin
                    if (pop) begin
                        head_s = tail_r;
                        if (push) begin
                            tail_s = push_entry;
                        end else begin
                            tail_s = tail_r;
                        end
                    end else begin
                        head_s = head_r;
                    end
                end
                default: begin
                    head_s = head_r;
                end
            endcase
            occ_s = occ_next(occ_r, push, pop);
        end
    end

    // Slot, occupancy and valid registers; reset clears the stored words.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_r  <= '0;
            tail_r  <= '0;
            occ_r   <= OCC_EMPTY;
            valid_r <= 1'b0;
        end else begin
            head_r  <= head_s;
            tail_r  <= tail_s;
            occ_r   <= occ_s;
            valid_r <= (occ_s != OCC_EMPTY);
        end
    end

    assign head       = head_r;
    assign head_valid = valid_r;
    assign occupancy  = occ_r;

endmodule

// File: rtl/fifo_read_streamer.sv
// Drains the async FIFO read side into a valid/ready stream through a
// two-word prefetch buffer, tags burst ends and counts delivered words.
module fifo_read_streamer
    import fifo_read_streamer_pkg::*;
#(
    parameter int DSIZE     = 8,
    parameter int BURST_LEN = 16,
    parameter int CNT_W     = 16
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic [DSIZE-1:0] rdata,
    input  logic             rempty,
    output logic             rout,
    input  logic             flush,
    output logic [DSIZE-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] word_count
);

    localparam int POS_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(BURST_LEN - 1);

    typedef struct packed {
        logic             last;
        logic [DSIZE-1:0] data;
    } entry_t;

    logic [POS_W-1:0] pos_r;
    logic [CNT_W-1:0] count_r;
    logic             pop_s;
    logic             xfer_s;
    entry_t           push_entry_s;
    entry_t           head_s;
    logic             head_valid_s;
    logic [1:0]       occ_s;

    // The read strobe looks only at registered occupancy and rempty, so the
    // downstream ready never reaches the FIFO combinationally.
    assign rout   = !rrst && !flush && !rempty && (occ_s != OCC_FULL);
    assign pop_s  = rout;
    assign xfer_s = head_valid_s && m_ready;

    assign push_entry_s.last = (pos_r == POS_LAST);
    assign push_entry_s.data = rdata;

    stream_buf2 #(
        .entry_t (entry_t)
    ) u_buf (
        .clk        (rclk),
        .rst        (rrst),
        .flush      (flush),
        .push       (pop_s),
        .push_entry (push_entry_s),
        .pop        (xfer_s),
        .head       (head_s),
        .head_valid (head_valid_s),
        .occupancy  (occ_s)
    );

    // Burst position advances per popped word and restarts on reset or flush.
    always_ff @(posedge rclk) begin
        if (rrst || flush) begin
            pos_r <= '0;
        end else if (pop_s) begin
            if (pos_r == POS_LAST) begin
                pos_r <= '0;
            end else begin
                pos_r <= pos_r + POS_W'(1);
            end
        end else begin
            pos_r <= pos_r;
        end
    end

    // Delivered-word counter; a handshake during flush still counts.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            count_r <= '0;
        end else if (xfer_s) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign m_data     = head_s.data;
    assign m_last     = head_s.last;
    assign m_valid    = head_valid_s;
    assign occupancy  = occ_s;
    assign word_count = count_r;

endmodule

// File: tb/tb_fifo_read_streamer.sv
// Scoreboard bench: a queue-based FIFO model feeds the read side, every
// popped word is pushed with its expected burst tag, and a monitor compares
// each stream handshake against the queue head.
module tb_fifo_read_streamer;

    localparam int BL = 16;

    logic        clk = 1'b0;
    logic        rrst, rempty, rout, flush, m_valid, m_ready, m_last;
    logic [7:0]  rdata, m_data;
    logic [1:0]  occupancy;
    logic [15:0] word_count;

    logic        b_rrst, b_rempty, b_rout, b_m_valid, b_m_last;
    logic [7:0]  b_rdata, b_m_data;
    logic [1:0]  b_occupancy;
    logic [3:0]  b_word_count;

    int tests = 0;
    int fails = 0;

    logic [7:0]  fq[$];
    logic [8:0]  exp_q[$];
    logic [7:0]  qb[$];
    int          pos_m = 0;
    logic [15:0] wc_m = 16'd0;
    int          n_pop = 0, n_xfer = 0, n_last = 0;
    logic [7:0]  last_seen = 8'h00;
    int          b_next = 0;

    logic       s_pop, s_xfer, s_flush, s_rst, bs_pop;
    logic [7:0] s_rdata;
    logic [8:0] front;

    always #5 clk = ~clk;

    fifo_read_streamer #(.DSIZE(8), .BURST_LEN(BL), .CNT_W(16)) dut (
        .rclk(clk), .rrst(rrst), .rdata(rdata), .rempty(rempty), .rout(rout),
        .flush(flush), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_last(m_last), .occupancy(occupancy), .word_count(word_count)
    );

    fifo_read_streamer #(.DSIZE(8), .BURST_LEN(1), .CNT_W(4)) dut_b (
        .rclk(clk), .rrst(b_rrst), .rdata(b_rdata), .rempty(b_rempty), .rout(b_rout),
        .flush(1'b0), .m_data(b_m_data), .m_valid(b_m_valid), .m_ready(1'b1),
        .m_last(b_m_last), .occupancy(b_occupancy), .word_count(b_word_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Main monitor: sample at the falling edge, apply the edge's effects just after the rising edge.
    always begin
        @(negedge clk);
        s_pop   = rout && !rempty;
        s_xfer  = m_valid && m_ready;
        s_flush = flush;
        s_rst   = rrst;
        s_rdata = rdata;
        check("rout", {31'd0, rout}, {31'd0, (!rrst && !flush && (fq.size() != 0) && (exp_q.size() < 2))});
        check("occupancy", {30'd0, occupancy}, exp_q.size());
        check("m_valid", {31'd0, m_valid}, {31'd0, (exp_q.size() != 0)});
        check("word_count", {16'd0, word_count}, {16'd0, wc_m});
        if (s_xfer && (exp_q.size() != 0)) begin
            front = exp_q.pop_front();
            check("m_data", {24'd0, m_data}, {24'd0, front[7:0]});
            check("m_last", {31'd0, m_last}, {31'd0, front[8]});
            if (m_last) begin
                n_last++;
                last_seen = m_data;
            end
            wc_m = wc_m + 16'd1;
            n_xfer++;
        end
        @(posedge clk);
        #1;
        if (s_rst) begin
            exp_q.delete();
            pos_m = 0;
            wc_m  = 16'd0;
        end else begin
            if (s_flush) begin
                exp_q.delete();
                pos_m = 0;
            end
            if (s_pop) begin
                exp_q.push_back({(pos_m == BL - 1), s_rdata});
                pos_m = (pos_m + 1) % BL;
            end
        end
        if (s_pop) begin
            void'(fq.pop_front());
            n_pop++;
        end
        rempty = (fq.size() == 0);
        rdata  = (fq.size() != 0) ? fq[0] : 8'h00;
    end

    // Second instance: burst length 1 and a 4-bit counter; words arrive in order 0,1,2...
    always begin
        @(negedge clk);
        bs_pop = b_rout && !b_rempty;
        if (b_m_valid) begin
            check("b_data", {24'd0, b_m_data}, b_next);
            check("b_last", {31'd0, b_m_last}, 32'd1);
            b_next++;
        end
        @(posedge clk);
        #1;
        if (bs_pop) void'(qb.pop_front());
        b_rempty = (qb.size() == 0);
        b_rdata  = (qb.size() != 0) ? qb[0] : 8'h00;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_word(input logic [7:0] v);
        fq.push_back(v);
        rempty = 1'b0;
        rdata  = fq[0];
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (((fq.size() != 0) || (exp_q.size() != 0)) && (n < budget)) begin
            tick();
            n++;
        end
        check(name, {31'd0, (n < budget)}, 32'd1);
    endtask

    task automatic do_reset();
        rrst = 1'b1;
        tick();
        rrst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base_pop, base_xfer, base_last, n;
        rrst = 1'b1; flush = 1'b0; m_ready = 1'b0;
        rempty = 1'b1; rdata = 8'h00;
        b_rrst = 1'b1; b_rempty = 1'b1; b_rdata = 8'h00;
        for (int i = 0; i < 18; i++) qb.push_back(8'(i));
        b_rempty = 1'b0; b_rdata = qb[0];

        // Reset with a word waiting in the FIFO: no read strobe during reset.
        push_word(8'h99);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_rout", {31'd0, rout}, 32'd0);
            tick();
        end
        rrst = 1'b0;
        @(negedge clk);
        check("post_rst_valid", {31'd0, m_valid}, 32'd0);
        check("post_rst_occ", {30'd0, occupancy}, 32'd0);
        check("post_rst_count", {16'd0, word_count}, 32'd0);
        m_ready = 1'b1;
        drain("drain_reset", 50);

        // Streaming 32 words at full rate.
        do_reset();
        base_last = n_last;
        for (int i = 1; i <= 32; i++) push_word(8'(i));
        @(negedge clk);
        check("stream_first_rout", {31'd0, rout}, 32'd1);
        check("stream_first_valid", {31'd0, m_valid}, 32'd0);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            check("stream_no_bubble", {31'd0, m_valid}, 32'd1);
        end
        @(negedge clk);
        check("stream_end_valid", {31'd0, m_valid}, 32'd0);
        check("stream_count", {16'd0, word_count}, 32'd32);
        check("stream_lasts", n_last - base_last, 32'd2);
        check("stream_last_word", {24'd0, last_seen}, 32'h20);
        tick();

        // Backpressure: two pops fill the buffer, then the strobe stays low.
        m_ready = 1'b0;
        base_pop = n_pop;
        push_word(8'h0A); push_word(8'h0B); push_word(8'h0C);
        repeat (5) tick();
        @(negedge clk);
        check("bp_pops", n_pop - base_pop, 32'd2);
        check("bp_occ", {30'd0, occupancy}, 32'd2);
        check("bp_head", {24'd0, m_data}, 32'h0A);
        check("bp_rout", {31'd0, rout}, 32'd0);
        tick();
        m_ready = 1'b1;
        drain("drain_bp", 50);

        // Single word followed by an empty FIFO.
        base_pop = n_pop; base_xfer = n_xfer;
        push_word(8'h55);
        drain("drain_single", 50);
        repeat (3) tick();
        check("single_pops", n_pop - base_pop, 32'd1);
        check("single_xfers", n_xfer - base_xfer, 32'd1);

        // Flush at burst position 5 with two words buffered.
        do_reset();
        for (int i = 0; i < 5; i++) push_word(8'h61 + 8'(i));
        drain("drain_pre_flush", 50);
        m_ready = 1'b0;
        push_word(8'h11); push_word(8'h22);
        for (int i = 0; i < 20; i++) push_word(8'h80 + 8'(i));
        repeat (4) tick();
        @(negedge clk);
        check("flush_pre_occ", {30'd0, occupancy}, 32'd2);
        check("flush_pre_head", {24'd0, m_data}, 32'h11);
        check("flush_pre_count", {16'd0, word_count}, 32'd5);
        tick();
        flush = 1'b1; m_ready = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clk);
        check("flush_count", {16'd0, word_count}, 32'd6);
        check("flush_valid", {31'd0, m_valid}, 32'd0);
        check("flush_occ", {30'd0, occupancy}, 32'd0);
        drain("drain_post_flush", 100);
        check("flush_burst_restart", {24'd0, last_seen}, 32'h8F);

        // Randomised traffic with random backpressure and occasional flushes.
        for (int i = 0; i < 400; i++) begin
            tick();
            m_ready = ($urandom_range(0, 1) == 1);
            flush   = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 2) != 0) push_word(8'($urandom));
        end
        tick();
        flush = 1'b0; m_ready = 1'b1;
        drain("drain_random", 1000);

        // Counter wrap on the 4-bit instance: 18 transfers leave 2.
        b_rrst = 1'b0;
        n = 0;
        while ((b_next < 18) && (n < 100)) begin
            tick();
            n++;
        end
        check("wrap_done", {31'd0, (n < 100)}, 32'd1);
        repeat (3) tick();
        check("wrap_count", {28'd0, b_word_count}, 32'd2);
        check("wrap_total", b_next, 32'd18);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
